// File: rtl/result_tx_pkg.sv
// Shared FSM state type and framing constants for the result UART transmit path.
package result_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } tx_state_t;

  localparam int         RESULT_WORDS   = 4;
  localparam int         BYTES_PER_WORD = 2;
  localparam logic [7:0] HEADER_BYTE    = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
// A load presented in the last stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
  import result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_nx;
  logic [BAUD_W-1:0] baud, baud_nx;
  logic [2:0]        bit_idx, bit_idx_nx;
  logic [7:0]        shreg, shreg_nx;
  logic              tx_nx;
  logic              bit_end;

  assign bit_end   = (baud == BAUD_LAST);
  assign byte_done = (state == STOP) && bit_end;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    state_nx   = state;
    baud_nx    = baud;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    tx_nx      = tx;
    if (state == START || state == DATA || state == STOP)
      baud_nx = bit_end ? '0 : baud + BAUD_W'(1);
    unique case (state)
      IDLE: begin
        if (load) begin
          state_nx = START;
          shreg_nx = byte_in;
          tx_nx    = 1'b0;
          baud_nx  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_idx_nx = 3'd0;
          tx_nx      = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx   = STOP;
            bit_idx_nx = 3'd0;
            tx_nx      = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            shreg_nx   = {1'b0, shreg[7:1]};
            tx_nx      = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (load) begin
            state_nx = START;
            shreg_nx = byte_in;
            tx_nx    = 1'b0;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      baud    <= baud_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      tx      <= tx_nx;
    end
  end

endmodule

// File: rtl/result_uart_tx.sv
// Snapshots r1..r4 on an end_process rising edge and streams them high byte first over 8N1 UART.
// Define RESULT_TX_HEADER_EN to prefix each stream with the HEADER_BYTE sync byte.
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              end_process,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r4,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output logic              overrun
);

`ifdef RESULT_TX_HEADER_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int         NUM_BYTES = RESULT_WORDS * BYTES_PER_WORD + HDR_BYTES;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_BYTES - 1);

  logic              end_prev;
  logic              trigger;
  logic              accept;
  logic              start_pending;
  logic [3:0]        byte_idx;
  logic [3:0]        sel_idx;
  logic [2:0]        data_idx;
  logic [15:0]       word16;
  logic [7:0]        byte_in;
  logic              load;
  logic              byte_done;
  logic [DATA_W-1:0] shadow [RESULT_WORDS];

  assign trigger = end_process & ~end_prev;
  // The tx_done cycle still counts as busy so a trigger landing there is flagged, not started.
  assign accept  = trigger & ~busy & ~tx_done;
  assign load    = start_pending | (byte_done & (byte_idx != LAST_IDX));

  // The first load sends byte 0; later loads are issued while byte_idx still names the outgoing byte.
  always_comb begin
    sel_idx  = start_pending ? 4'd0 : byte_idx + 4'd1;
    data_idx = 3'(sel_idx - 4'(HDR_BYTES));
    word16   = 16'(shadow[data_idx[2:1]]);
    byte_in  = data_idx[0] ? word16[7:0] : word16[15:8];
`ifdef RESULT_TX_HEADER_EN
    if (sel_idx == 4'd0) byte_in = HEADER_BYTE;
`endif
  end

  // NOTE: the snapshot is pure data, always written before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow[0] <= r1;
      shadow[1] <= r2;
      shadow[2] <= r3;
      shadow[3] <= r4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      end_prev      <= 1'b0;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
      overrun       <= 1'b0;
      start_pending <= 1'b0;
      byte_idx      <= '0;
    end else begin
      end_prev <= end_process;
      tx_done  <= 1'b0;
      if (trigger && (busy || tx_done))
        overrun <= 1'b1;
      if (accept) begin
        busy          <= 1'b1;
        start_pending <= 1'b1;
        byte_idx      <= '0;
      end else if (start_pending) begin
        start_pending <= 1'b0;
      end else if (byte_done) begin
        if (byte_idx == LAST_IDX) begin
          busy     <= 1'b0;
          tx_done  <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + 4'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .byte_in  (byte_in),
    .tx       (tx),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: decodes the UART stream at bit centres against hand-written bytes.
module tb_result_uart_tx;

  localparam int CPB = 87;
  localparam int MID = CPB / 2;
`ifdef RESULT_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NB       = 8 + HDR;
  localparam int XFER_CYC = 1 + 10 * CPB * NB;

  localparam int ACT_NONE  = 0;
  localparam int ACT_HOLD  = 1;
  localparam int ACT_PULSE = 2;
  localparam int ACT_RESET = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        end_process;
  logic [11:0] r1, r2, r3, r4;
  logic        tx, busy, tx_done, overrun;

  int n_cmp     = 0;
  int n_fail    = 0;
  int edge_n    = 0;
  int done_cnt  = 0;
  int done_edge = 0;
  int idle_bad  = 0;

  result_uart_tx #(
    .DATA_W      (12),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .end_process(end_process),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .r4         (r4),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (tx_done === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_edge <= edge_n;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic decode(input int s, output logic [7:0] b, output logic frame_ok);
    wait_edge(s + MID);
    frame_ok = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_edge(s + (i + 1) * CPB + MID);
      b[i] = tx;
    end
    wait_edge(s + 9 * CPB + MID);
    frame_ok = frame_ok & (tx === 1'b1);
  endtask

  task automatic xfer(input string tag, input logic [63:0] exp_bytes, input int act);
    int         t, s, d0;
    logic [7:0] got, expb;
    logic       frame_ok;
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    end_process = 1'b1;
    @(posedge clk);
    #1;
    t = edge_n;
    check({tag, "_busy_at_trigger"}, 32'(busy), 32'd1);
    check({tag, "_tx_idle_at_trigger"}, 32'(tx), 32'd1);
    wait_edge(t + 1);
    check({tag, "_tx_low_next_edge"}, 32'(tx), 32'd0);
    for (int k = 0; k < NB; k++) begin
      s = t + 1 + 10 * CPB * k;
      if (act == ACT_PULSE && k == 3) begin
        wait_edge(s + 5);
        end_process = 1'b0;
        wait_edge(s + 6);
        end_process = 1'b1;
        wait_edge(s + 7);
        check({tag, "_overrun_set"}, 32'(overrun), 32'd1);
        wait_edge(s + 9);
        end_process = 1'b0;
      end
      if (act == ACT_RESET && k == 5) begin
        wait_edge(s + 100);
        rst_n = 1'b0;
        wait_edge(s + 101);
        check({tag, "_tx_after_reset"}, 32'(tx), 32'd1);
        check({tag, "_busy_after_reset"}, 32'(busy), 32'd0);
        check({tag, "_overrun_after_reset"}, 32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_edge(s + 2000);
        check({tag, "_no_done_after_abort"}, 32'(done_cnt - d0), 32'd0);
        check({tag, "_tx_idle_after_abort"}, 32'(tx), 32'd1);
        return;
      end
      decode(s, got, frame_ok);
      expb = (k < HDR) ? 8'hA5 : exp_bytes[63 - 8 * (k - HDR) -: 8];
      check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(expb));
      check($sformatf("%s_frame%0d", tag, k), 32'(frame_ok), 32'd1);
      if (k == 0) begin
        if (act == ACT_HOLD) begin
          r1 = 12'hFFF;
          r2 = 12'hFFF;
          r3 = 12'hFFF;
          r4 = 12'hFFF;
        end else begin
          end_process = 1'b0;
        end
      end
    end
    wait_edge(t + XFER_CYC + 1);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_done_latency"}, 32'(done_edge - t), 32'(XFER_CYC));
    check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
    if (act == ACT_HOLD) begin
      check({tag, "_no_overrun"}, 32'(overrun), 32'd0);
      end_process = 1'b0;
    end
    if (act == ACT_PULSE)
      check({tag, "_overrun_sticky"}, 32'(overrun), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    end_process = 1'b0;
    r1 = '0;
    r2 = '0;
    r3 = '0;
    r4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tx_done", 32'(tx_done), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) idle_bad++;
    end
    check("idle_quiet", 32'(idle_bad), 32'd0);

    r1 = 12'h123; r2 = 12'h456; r3 = 12'h789; r4 = 12'hABC;
    xfer("basic", 64'h01_23_04_56_07_89_0A_BC, ACT_NONE);

    r1 = 12'h5A3; r2 = 12'h0F0; r3 = 12'hC3C; r4 = 12'h00F;
    xfer("hold", 64'h05_A3_00_F0_0C_3C_00_0F, ACT_HOLD);

    r1 = 12'hDEF; r2 = 12'h012; r3 = 12'h345; r4 = 12'h678;
    xfer("pulse", 64'h0D_EF_00_12_03_45_06_78, ACT_PULSE);

    r1 = 12'h123; r2 = 12'h456; r3 = 12'h789; r4 = 12'hABC;
    xfer("abort", 64'h01_23_04_56_07_89_0A_BC, ACT_RESET);

    r1 = 12'hFED; r2 = 12'hCBA; r3 = 12'h987; r4 = 12'h654;
    xfer("after_reset", 64'h0F_ED_0C_BA_09_87_06_54, ACT_NONE);

    r1 = 12'h000; r2 = 12'h000; r3 = 12'h000; r4 = 12'h000;
    xfer("zeros", 64'h00_00_00_00_00_00_00_00, ACT_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
